riscv_div_unit: RTL

Multi-cycle integer divider for the RV32M execute stage, implementing DIV, DIVU, REM and REMU. It uses a restoring shift-subtract algorithm that produces one quotient bit per cycle. It complements the combinational add/subtract datapath: the ALU issues a request with `start`, stalls while `busy` is high, and captures `result` on the one-cycle `done` pulse. Latency is fixed for every operand combination, including the RISC-V special cases.

---
 rtl/riscv_div_pkg.sv | 23 ++
 rtl/RippleCarryAdder.sv | 23 ++
 rtl/riscv_div_unit_div_step.sv | 31 +++
 rtl/riscv_div_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/riscv_div_pkg.sv
// Shared definitions for the RV32M multi-cycle divider: op codes, FSM states, sizing.
package riscv_div_pkg;

    localparam int DIV_N = 32;
    localparam int DIV_CNT_W = $clog2(DIV_N);

    // op is funct3[1:0]; bit 0 set means unsigned, bit 1 set means remainder
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/RippleCarryAdder.sv
// Plain ripple-carry adder; with b inverted and cin=1 it subtracts, cout being not-borrow.
module RippleCarryAdder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/riscv_div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to subtract B.
module div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   r,
    input  logic         q_msb,
    input  logic [N-1:0] b,
    output logic [N:0]   r_next,
    output logic         q_bit
);

    logic [N:0] t;
    logic [N:0] diff;
    logic       no_borrow;

    assign t = {r[N-1:0], q_msb};

    RippleCarryAdder #(.N(N + 1)) u_sub (
        .a    (t),
        .b    (~{1'b0, b}),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    // R stays below B so r[N] is zero in practice; if it were set, T would
    // exceed N+1 bits and certainly be >= B, so it also forces a subtract.
    assign q_bit  = no_borrow | r[N];
    assign r_next = q_bit ? diff : t;

endmodule

// File: rtl/riscv_div_unit.sv
// RV32M divider (DIV/DIVU/REM/REMU): magnitude restoring divide, then sign and special-case fixup.
module riscv_div_unit
    import riscv_div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [1:0]   dbg_state
);

    // Handshake: a request is accepted on any edge where start=1 and busy=0
    // (including the done cycle); result is valid exactly in the cycle done=1.
    localparam int CW = $clog2(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    logic [1:0]   state;
    logic [CW-1:0] cnt;
    logic [N:0]   r_q;
    logic [N-1:0] q_q;
    logic [N-1:0] b_q;
    logic [N-1:0] a_raw;
    logic [N-1:0] b_raw;
    logic [1:0]   op_q;
    logic         neg_q;
    logic         neg_r;

    logic         sgn_in;
    logic [N-1:0] a_mag;
    logic [N-1:0] b_mag;
    logic [N:0]   r_next;
    logic         q_bit;
    logic [N-1:0] quot;
    logic [N-1:0] rem;
    logic [N-1:0] fix_res;

    assign dbg_state = state;

    always_comb begin
        sgn_in = is_signed_op(op);
        a_mag  = (sgn_in && a[N-1]) ? -a : a;
        b_mag  = (sgn_in && b[N-1]) ? -b : b;
    end

    div_step #(.N(N)) u_step (
        .r      (r_q),
        .q_msb  (q_q[N-1]),
        .b      (b_q),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    // Divide-by-zero wins over signed overflow; both bypass the sign fixup.
    always_comb begin
        quot = neg_q ? -q_q : q_q;
        rem  = neg_r ? -r_q[N-1:0] : r_q[N-1:0];
        if (b_raw == '0) begin
            quot = '1;
            rem  = a_raw;
        end else if (is_signed_op(op_q) && a_raw == MIN_NEG && b_raw == '1) begin
            quot = a_raw;
            rem  = '0;
        end
        fix_res = op_q[1] ? rem : quot;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            r_q    <= '0;
            q_q    <= '0;
            b_q    <= '0;
            a_raw  <= '0;
            b_raw  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CALC;
                        busy  <= 1'b1;
                        op_q  <= op;
                        a_raw <= a;
                        b_raw <= b;
                        q_q   <= a_mag;
                        b_q   <= b_mag;
                        neg_q <= sgn_in & (a[N-1] ^ b[N-1]);
                        neg_r <= sgn_in & a[N-1];
                        r_q   <= '0;
                        cnt   <= CW'(N - 1);
                    end
                end
                S_CALC: begin
                    r_q <= r_next;
                    q_q <= {q_q[N-2:0], q_bit};
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    result <= fix_res;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
